// File: rtl/mux_scan_capture_pkg.sv
// mux_scan_capture_pkg: channel count, select width and FSM encoding shared by
// the scan controller and the 16:1 select tree. Rev 1.0
`default_nettype none

package mux_scan_capture_pkg;

  localparam int NCH  = 16;
  localparam int SELW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mux_scan_capture_lowest_set_idx.sv
// lowest_set_idx: index of the lowest set bit of a channel vector (0 when empty).
// Rev 1.0
`default_nettype none

module lowest_set_idx
  import mux_scan_capture_pkg::*;
(
  input  logic [NCH-1:0]  vec_i,
  output logic [SELW-1:0] idx_o
);

  // Scan downward so the last hit, the lowest set bit, wins.
  always_comb begin
    idx_o = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = SELW'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_scan_capture.sv
// mux_scan_capture: walks the enabled channels of a 16:1 select tree, samples Y
// after a settle time and delivers the word over valid/ready. Rev 1.0
`default_nettype none

module mux_scan_capture
  import mux_scan_capture_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NCH-1:0]  chan_mask,
  output logic [SELW-1:0] sel,
  input  logic            mux_y,
  output logic            busy,
  output logic [NCH-1:0]  data_out,
  output logic            valid,
  input  logic            ready
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [NCH-1:0]  rem_q, rem_d;
  logic [NCH-1:0]  shw_q, shw_d;
  logic [NCH-1:0]  data_q, data_d;
  logic [3:0]      cnt_q, cnt_d;

  logic [NCH-1:0]  rem_upd;
  logic [NCH-1:0]  shw_upd;
  logic [NCH-1:0]  lsi_vec;
  logic [SELW-1:0] lsi_idx;

  // One finder serves both the start decision and the next-channel search.
  always_comb begin
    rem_upd        = rem_q & ~({{(NCH-1){1'b0}}, 1'b1} << sel_q);
    shw_upd        = shw_q;
    shw_upd[sel_q] = mux_y;
    lsi_vec        = (state_q == ST_IDLE) ? chan_mask : rem_upd;
  end

  lowest_set_idx u_lsi (
    .vec_i (lsi_vec),
    .idx_o (lsi_idx)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    shw_d   = shw_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (|chan_mask) begin
            rem_d   = chan_mask;
            shw_d   = '0;
            sel_d   = lsi_idx;
            cnt_d   = CNT_INIT;
            state_d = ST_SETTLE;
          end else begin
            data_d  = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) state_d = ST_SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_SAMPLE: begin
        shw_d = shw_upd;
        rem_d = rem_upd;
        if (|rem_upd) begin
          sel_d   = lsi_idx;
          cnt_d   = CNT_INIT;
          state_d = ST_SETTLE;
        end else begin
          data_d  = shw_upd;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      rem_q   <= '0;
      shw_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      shw_q   <= shw_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel      = sel_q;
  assign data_out = data_q;
  assign busy     = (state_q != ST_IDLE);
  assign valid    = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_capture.sv
// tb_mux_scan_capture: drives scans through a behavioural 16:1 tree and checks
// select walk, latency, captured word and handshake against a reference model.
`default_nettype none

module tb_mux_scan_capture;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] chan_mask;
  logic [3:0]  sel;
  logic        mux_y;
  logic        busy;
  logic [15:0] data_out;
  logic        valid;
  logic        ready;

  logic [15:0] mux_in;
  logic [3:0]  last_sel;
  int          compared;
  int          mismatched;

  assign mux_y = mux_in[sel];

  always #5 clk = ~clk;

  mux_scan_capture #(.SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .chan_mask (chan_mask),
    .sel       (sel),
    .mux_y     (mux_y),
    .busy      (busy),
    .data_out  (data_out),
    .valid     (valid),
    .ready     (ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scan scenario: the model derives the visit order, per-channel hold time,
  // sample instant and word purely from the latched mask and the tree inputs.
  task automatic run_scan(input logic [15:0] m, input bit rnd, input int hold);
    int          vis[$];
    int          n;
    int          per;
    int          ch;
    logic [15:0] exp_w;
    per   = SETTLE + 1;
    exp_w = '0;
    for (int i = 0; i < 16; i++) if (m[i]) vis.push_back(i);
    n = vis.size();
    chan_mask = m;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < n * per; j++) begin
      ch = vis[j / per];
      compared++;
      if (sel !== 4'(ch) || busy !== 1'b1 || valid !== 1'b0) begin
        mismatched++;
        $display("FAIL scan_walk cyc=%0d: sel=%0d busy=%b valid=%b, want sel=%0d busy=1 valid=0",
                 j, sel, busy, valid, ch);
      end
      if (rnd) begin
        mux_in    = 16'($urandom);
        chan_mask = 16'($urandom);
        ready     = 1'($urandom_range(0, 1));
        start     = 1'($urandom_range(0, 1));
      end
      if (j % per == per - 1) exp_w[ch] = mux_in[ch];
      step();
    end
    start = 1'b0;
    if (n > 0) last_sel = 4'(vis[n-1]);
    compared++;
    if (valid !== 1'b1 || busy !== 1'b1 || data_out !== exp_w || sel !== last_sel) begin
      mismatched++;
      $display("FAIL scan_done n=%0d: valid=%b busy=%b data=%h sel=%0d, want valid=1 busy=1 data=%h sel=%0d",
               n, valid, busy, data_out, sel, exp_w, last_sel);
    end
    for (int h = 0; h < hold; h++) begin
      ready     = 1'b0;
      start     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chan_mask = 16'($urandom);
      step();
      compared++;
      if (valid !== 1'b1 || busy !== 1'b1 || data_out !== exp_w || sel !== last_sel) begin
        mismatched++;
        $display("FAIL hold h=%0d: valid=%b busy=%b data=%h sel=%0d, want valid=1 busy=1 data=%h sel=%0d",
                 h, valid, busy, data_out, sel, exp_w, last_sel);
      end
    end
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    compared++;
    if (valid !== 1'b0 || busy !== 1'b0 || data_out !== exp_w || sel !== last_sel) begin
      mismatched++;
      $display("FAIL handshake: valid=%b busy=%b data=%h sel=%0d, want valid=0 busy=0 data=%h sel=%0d",
               valid, busy, data_out, sel, exp_w, last_sel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; chan_mask = '0; ready = 1'b1; mux_in = '0;
    last_sel = '0;
    step();
    step();
    compared++;
    if (sel !== 4'd0 || data_out !== 16'h0 || valid !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset: sel=%0d data=%h valid=%b busy=%b, want all 0", sel, data_out, valid, busy);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_scan();
    mux_in = 16'hA5C3;
    run_scan(16'hFFFF, 1'b0, 0);
  endtask

  task automatic test_end_channels();
    mux_in = 16'hFFFF;
    run_scan(16'h8001, 1'b0, 0);
  endtask

  task automatic test_zero_mask();
    mux_in = 16'hFFFF;
    run_scan(16'h0000, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    mux_in = 16'h3C5A;
    run_scan(16'h0F0F, 1'b0, 10);
  endtask

  task automatic test_reset_mid_scan();
    mux_in    = 16'hFFFF;
    chan_mask = 16'hFFFF;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 19; i++) step();
    #2 rst = 1'b1;
    #1;
    compared++;
    if (sel !== 4'd0 || data_out !== 16'h0 || valid !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset: sel=%0d data=%h valid=%b busy=%b, want all 0", sel, data_out, valid, busy);
    end
    step();
    rst      = 1'b0;
    last_sel = '0;
    step();
    compared++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      mismatched++;
      $display("FAIL post_reset_idle: busy=%b valid=%b, want 0 0", busy, valid);
    end
    mux_in = 16'h0010;
    run_scan(16'h0010, 1'b0, 0);
  endtask

  task automatic test_random_back_to_back();
    logic [15:0] m;
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 5))
        0:       m = 16'h0000;
        1:       m = 16'hFFFF;
        default: m = 16'($urandom & $urandom);
      endcase
      run_scan(m, 1'b1, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_full_scan();
    test_end_channels();
    test_zero_mask();
    test_backpressure();
    test_reset_mid_scan();
    test_random_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
